apb4_arbiter_master: RTL

- Shares one APB4 completer port between NUM_REQ local requesters.
- Each requester has a simple req/done command interface.
- Round-robin arbitration; sequences APB4 SETUP/ACCESS phases and honours PREADY wait states.
- Returns PRDATA/PSLVERR to the granted requester.
- Sits between the register-block cpuif bus and multiple internal masters (test sequencer, debug bridge, DMA-style initialiser).

---
 rtl/apb4_arb_pkg.sv | 13 +
 rtl/apb4_arbiter_master_rr_arbiter.sv | 30 +++
 rtl/apb4_arbiter_master.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/apb4_arb_pkg.sv
// apb4_arb_pkg: shared FSM state type and APB constants for apb4_arbiter_master.
package apb4_arb_pkg;

   localparam int PROT_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/apb4_arbiter_master_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. The search starts one past
// i_ptr (the last granted index) and wraps, so the last winner ranks lowest.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant
);

   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   // One-hot grant of the first set request after the pointer.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path infers a latch.
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb4_arbiter_master.sv
// apb4_arbiter_master: shares one APB4 completer port between NUM_REQ local
// requesters with round-robin arbitration and registered APB outputs.
// Optional ACCESS-phase timeout: define APB4_ARB_TIMEOUT_EN.
module apb4_arbiter_master
   import apb4_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ-1:0]                 req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
   input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_strb,
   input  logic [NUM_REQ*PROT_W-1:0]          req_prot,
   output logic [NUM_REQ-1:0]                 req_done,
   output logic [DATA_WIDTH-1:0]              req_rdata,
   output logic                               req_err,
   output logic                               PSEL,
   output logic                               PENABLE,
   output logic                               PWRITE,
   output logic [PROT_W-1:0]                  PPROT,
   output logic [ADDR_WIDTH-1:0]              PADDR,
   output logic [DATA_WIDTH-1:0]              PWDATA,
   output logic [DATA_WIDTH/8-1:0]            PSTRB,
   input  logic [DATA_WIDTH-1:0]              PRDATA,
   input  logic                               PREADY,
   input  logic                               PSLVERR
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int PTR_W  = $clog2(NUM_REQ);

   // Widths depend on this module's parameters, so the command struct lives here.
   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_W-1:0]     strb;
      logic [PROT_W-1:0]     prot;
   } cmd_t;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t                r_state, w_state_nxt;
   logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
   cmd_t                  r_cmd, w_cmd_nxt, w_sel_cmd;
   logic                  r_psel, w_psel_nxt;
   logic                  r_penable, w_penable_nxt;
   logic [NUM_REQ-1:0]    r_done, w_done_nxt;
   logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
   logic                  r_err, w_err_nxt;
   logic [NUM_REQ-1:0]    w_grant;
   logic [PTR_W-1:0]      w_grant_idx;
   logic                  w_timeout;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant)
   );

   // Encode the one-hot grant and select that requester's command slice.
   always_comb begin
      w_grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) w_grant_idx = PTR_W'(i);
      end
      w_sel_cmd.write = req_write[w_grant_idx];
      w_sel_cmd.addr  = req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      w_sel_cmd.wdata = req_wdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      // Reads drive no byte lanes.
      w_sel_cmd.strb  = req_write[w_grant_idx] ? req_strb[w_grant_idx*STRB_W +: STRB_W] : '0;
      w_sel_cmd.prot  = req_prot[w_grant_idx*PROT_W +: PROT_W];
   end

`ifdef APB4_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] r_tmo_cnt;

   assign w_timeout = !PREADY && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Count ACCESS cycles spent waiting; cleared while in SETUP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
      end else if (r_state == SETUP) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ACCESS && !PREADY) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state and next-output logic; every APB output is a register.
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_cmd_nxt     = r_cmd;
      w_psel_nxt    = r_psel;
      w_penable_nxt = r_penable;
      w_done_nxt    = '0;
      w_rdata_nxt   = '0;
      w_err_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_cmd_nxt     = w_sel_cmd;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_ptr_nxt     = w_grant_idx;
               w_state_nxt   = SETUP;
            end
         end
         SETUP: begin
            w_penable_nxt = 1'b1;
            w_state_nxt   = ACCESS;
         end
         ACCESS: begin
            if (PREADY || w_timeout) begin
               w_psel_nxt      = 1'b0;
               w_penable_nxt   = 1'b0;
               w_cmd_nxt.addr  = '0;
               w_cmd_nxt.wdata = '0;
               w_cmd_nxt.strb  = '0;
               // r_ptr holds the index granted for this transfer.
               w_done_nxt      = NUM_REQ'(1) << r_ptr;
               w_rdata_nxt     = (PREADY && !r_cmd.write) ? PRDATA : '0;
               w_err_nxt       = PREADY ? PSLVERR : 1'b1;
               w_state_nxt     = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= PTR_W'(NUM_REQ - 1);
         r_cmd     <= '0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_done    <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cmd     <= w_cmd_nxt;
         r_psel    <= w_psel_nxt;
         r_penable <= w_penable_nxt;
         r_done    <= w_done_nxt;
         r_rdata   <= w_rdata_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_cmd.write;
   assign PPROT     = r_cmd.prot;
   assign PADDR     = r_cmd.addr;
   assign PWDATA    = r_cmd.wdata;
   assign PSTRB     = r_cmd.strb;
   assign req_done  = r_done;
   assign req_rdata = r_rdata;
   assign req_err   = r_err;

endmodule
